// File: rtl/snake_pkg.sv
// Shared game status, direction and draw codes, playfield bounds and food LFSR helpers.
package snake_pkg;

    typedef enum logic [1:0] {
        ST_RESTART = 2'b00,
        ST_START   = 2'b01,
        ST_PLAY    = 2'b10,
        ST_DIE     = 2'b11
    } game_state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        DRAW_NONE = 2'b00,
        DRAW_HEAD = 2'b01,
        DRAW_BODY = 2'b10,
        DRAW_WALL = 2'b11
    } draw_t;

    localparam logic [5:0] X_MIN = 6'd1;
    localparam logic [5:0] X_MAX = 6'd38;
    localparam logic [5:0] Y_MIN = 6'd1;
    localparam logic [5:0] Y_MAX = 6'd28;

    // Fibonacci LFSR, taps 12,11,10,4; shifts toward the MSB.
    function automatic logic [11:0] lfsr_next(input logic [11:0] s);
        return {s[10:0], s[11] ^ s[10] ^ s[9] ^ s[3]};
    endfunction

    function automatic logic in_grid(input logic [5:0] x, input logic [5:0] y);
        return (x >= X_MIN) && (x <= X_MAX) && (y >= Y_MIN) && (y <= Y_MAX);
    endfunction

endpackage

// File: rtl/snake_food_lfsr.sv
// Free-running food LFSR; latches the first in-grid candidate while requested and empty.
// One cycle from an in-grid candidate to food_valid; clear has priority over placement.
module snake_food_lfsr
    import snake_pkg::*;
#(
    parameter logic [11:0] LFSR_SEED = 12'hACE
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_req,
    input  logic       i_clr,
    output logic [5:0] o_food_x,
    output logic [5:0] o_food_y,
    output logic       o_food_valid
);

    logic [11:0] r_lfsr;
    logic [5:0]  r_food_x;
    logic [5:0]  r_food_y;
    logic        r_food_valid;
    logic [5:0]  w_cand_x;
    logic [5:0]  w_cand_y;

    assign w_cand_x = r_lfsr[5:0];
    assign w_cand_y = {1'b0, r_lfsr[10:6]};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_lfsr       <= LFSR_SEED;
            r_food_x     <= 6'd0;
            r_food_y     <= 6'd0;
            r_food_valid <= 1'b0;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
            if (i_clr) begin
                r_food_valid <= 1'b0;
            end else if (i_req && !r_food_valid && in_grid(w_cand_x, w_cand_y)) begin
                r_food_x     <= w_cand_x;
                r_food_y     <= w_cand_y;
                r_food_valid <= 1'b1;
            end
        end
    end

    assign o_food_x     = r_food_x;
    assign o_food_y     = r_food_y;
    assign o_food_valid = r_food_valid;

endmodule

// File: rtl/snake_game_ctrl.sv
// Game sequencer: START/PLAY/DIE/RESTART, move tick, eat detection, death flash, snake re-init.
// move_tick is combinational from the tick counter; add_cube/score/food update one cycle after eat.
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int          TICK_DIV  = 12500000,
    parameter int          FLASH_DIV = 6250000,
    parameter int          FLASH_NUM = 8,
    parameter int          MAX_LEN   = 16,
    parameter logic [11:0] LFSR_SEED = 12'hACE
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start_press,
    input  logic       i_hit_wall,
    input  logic       i_hit_body,
    input  logic [5:0] i_head_x,
    input  logic [5:0] i_head_y,
    input  logic [6:0] i_cube_num,
    output logic [1:0] o_game_status,
    output logic       o_move_tick,
    output logic       o_add_cube,
    output logic       o_snake_rst_n,
    output logic       o_die_flash,
    output logic [5:0] o_food_x,
    output logic [5:0] o_food_y,
    output logic       o_food_valid,
    output logic [7:0] o_score
);

    game_state_t r_state;
    game_state_t w_next;
    logic [23:0] r_tick_cnt;
    logic [23:0] r_flash_cnt;
    logic [7:0]  r_flash_num;
    logic        r_die_flash;
    logic        r_add_cube;
    logic        r_snake_rst_n;
    logic [7:0]  r_score;

    logic        w_hit;
    logic        w_eat;
    logic        w_eat_ok;
    logic        w_move_tick;
    logic        w_tick_last;
    logic        w_flash_wrap;
    logic        w_flash_last;
    logic        w_food_req;
    logic        w_food_clr;

    assign w_hit        = i_hit_wall | i_hit_body;
    assign w_eat        = o_food_valid && (i_head_x == o_food_x) && (i_head_y == o_food_y);
    assign w_tick_last  = (r_tick_cnt == 24'(TICK_DIV - 1));
    assign w_flash_wrap = (r_flash_cnt == 24'(FLASH_DIV - 1));
    assign w_flash_last = (r_flash_num == 8'(FLASH_NUM - 1));

    always_comb begin
        w_next      = r_state;
        w_move_tick = 1'b0;
        w_eat_ok    = 1'b0;
        case (r_state)
            ST_START: begin
                if (i_start_press) w_next = ST_PLAY;
            end
            ST_PLAY: begin
                // A collision suppresses the step and any eat in the same cycle.
                if (w_hit) begin
                    w_next = ST_DIE;
                end else begin
                    w_move_tick = w_tick_last;
                    w_eat_ok    = w_eat;
                end
            end
            ST_DIE: begin
                if (w_flash_wrap && w_flash_last) w_next = ST_RESTART;
            end
            default: w_next = ST_START;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_START;
            r_tick_cnt    <= 24'd0;
            r_flash_cnt   <= 24'd0;
            r_flash_num   <= 8'd0;
            r_die_flash   <= 1'b1;
            r_add_cube    <= 1'b0;
            r_snake_rst_n <= 1'b0;
            r_score       <= 8'd0;
        end else begin
            r_state       <= w_next;
            r_add_cube    <= w_eat_ok && (i_cube_num < 7'(MAX_LEN));
            r_snake_rst_n <= (w_next != ST_RESTART);

            if (r_state == ST_START && i_start_press) begin
                r_score <= 8'd0;
            end else if (w_eat_ok && r_score != 8'hFF) begin
                r_score <= r_score + 8'd1;
            end

            if (r_state == ST_PLAY) begin
                r_tick_cnt <= w_tick_last ? 24'd0 : r_tick_cnt + 24'd1;
            end else begin
                r_tick_cnt <= 24'd0;
            end

            if (r_state == ST_DIE) begin
                if (w_flash_wrap) begin
                    r_flash_cnt <= 24'd0;
                    r_flash_num <= w_flash_last ? 8'd0 : r_flash_num + 8'd1;
                    r_die_flash <= w_flash_last ? 1'b1 : ~r_die_flash;
                end else begin
                    r_flash_cnt <= r_flash_cnt + 24'd1;
                end
            end else begin
                r_flash_cnt <= 24'd0;
                r_flash_num <= 8'd0;
                r_die_flash <= 1'b1;
            end
        end
    end

    assign w_food_req = (r_state == ST_PLAY);
    assign w_food_clr = w_eat_ok || (r_state != ST_PLAY);

    snake_food_lfsr #(
        .LFSR_SEED (LFSR_SEED)
    ) u_food (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_req        (w_food_req),
        .i_clr        (w_food_clr),
        .o_food_x     (o_food_x),
        .o_food_y     (o_food_y),
        .o_food_valid (o_food_valid)
    );

    assign o_game_status = r_state;
    assign o_move_tick   = w_move_tick;
    assign o_add_cube    = r_add_cube;
    assign o_snake_rst_n = r_snake_rst_n;
    assign o_die_flash   = r_die_flash;
    assign o_score       = r_score;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl with short tick/flash dividers and an independent food model.
module tb_snake_game_ctrl;

    logic       clk = 1'b0;
    logic       reset, start_press, hit_wall, hit_body;
    logic [5:0] head_x, head_y;
    logic [6:0] cube_num;
    logic [1:0] game_status;
    logic       move_tick, add_cube, snake_rst_n, die_flash, food_valid;
    logic [5:0] food_x, food_y;
    logic [7:0] score;

    int n_vec = 0;
    int n_mis = 0;

    logic [11:0] m_lfsr;
    logic [5:0]  m_fx = 6'd0;
    logic [5:0]  m_fy = 6'd0;

    always #5 clk = ~clk;

    snake_game_ctrl #(
        .TICK_DIV  (4),
        .FLASH_DIV (2),
        .FLASH_NUM (4),
        .MAX_LEN   (16),
        .LFSR_SEED (12'hACE)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_start_press (start_press),
        .i_hit_wall    (hit_wall),
        .i_hit_body    (hit_body),
        .i_head_x      (head_x),
        .i_head_y      (head_y),
        .i_cube_num    (cube_num),
        .o_game_status (game_status),
        .o_move_tick   (move_tick),
        .o_add_cube    (add_cube),
        .o_snake_rst_n (snake_rst_n),
        .o_die_flash   (die_flash),
        .o_food_x      (food_x),
        .o_food_y      (food_y),
        .o_food_valid  (food_valid),
        .o_score       (score)
    );

    // Reference LFSR: taps 12,11,10,4 written out directly.
    always @(posedge clk) begin
        if (reset) m_lfsr <= 12'hACE;
        else       m_lfsr <= {m_lfsr[10:0], m_lfsr[11] ^ m_lfsr[10] ^ m_lfsr[9] ^ m_lfsr[3]};
    end

    // Predict the cell the controller should latch on the next edge.
    always @(negedge clk) begin
        logic [5:0] cx, cy;
        cx = m_lfsr[5:0];
        cy = {1'b0, m_lfsr[10:6]};
        if (!reset && game_status == 2'b10 && !food_valid &&
            cx >= 6'd1 && cx <= 6'd38 && cy >= 6'd1 && cy <= 6'd28) begin
            m_fx = cx;
            m_fy = cy;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic press();
        start_press = 1'b1;
        cyc();
        start_press = 1'b0;
    endtask

    task automatic wait_food();
        for (int i = 0; i < 100 && !food_valid; i++) cyc();
        chk("food_valid", food_valid, 1);
        chk("food_x", food_x, m_fx);
        chk("food_y", food_y, m_fy);
        chk("food_x_rng", (food_x >= 1 && food_x <= 38), 1);
        chk("food_y_rng", (food_y >= 1 && food_y <= 28), 1);
    endtask

    task automatic eat(input logic [6:0] len, input logic [7:0] exp_score, input logic exp_add);
        head_x   = food_x;
        head_y   = food_y;
        cube_num = len;
        cyc();
        head_x = 6'd0;
        head_y = 6'd0;
        chk("eat_add_cube", add_cube, exp_add);
        chk("eat_score", score, exp_score);
        chk("eat_food_drop", food_valid, 0);
        cyc();
        chk("add_cube_1cyc", add_cube, 0);
    endtask

    initial begin
        reset = 1'b1; start_press = 1'b0; hit_wall = 1'b0; hit_body = 1'b0;
        head_x = 6'd0; head_y = 6'd0; cube_num = 7'd3;
        repeat (3) cyc();

        // 1: reset values and idle START
        chk("rst_status", game_status, 2'b01);
        chk("rst_snake_rst_n", snake_rst_n, 0);
        chk("rst_die_flash", die_flash, 1);
        chk("rst_food_valid", food_valid, 0);
        chk("rst_food_xy", {food_x, food_y}, 0);
        chk("rst_score", score, 0);
        chk("rst_lfsr", dut.u_food.r_lfsr, 12'hACE);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            chk("idle_move_tick", move_tick, 0);
            chk("idle_rst_n", snake_rst_n, 1);
            chk("idle_status", game_status, 2'b01);
        end

        // 2: start, tick cadence, first food
        press();
        chk("play_status", game_status, 2'b10);
        for (int k = 0; k < 12; k++) begin
            chk("move_tick", move_tick, (k % 4 == 3));
            cyc();
        end
        wait_food();

        // 3: eat with room to grow
        eat(7'd3, 8'd1, 1'b1);
        wait_food();

        // 4: eat at full length
        eat(7'd16, 8'd2, 1'b0);
        wait_food();

        // 5: hit and eat together, hit wins; then flash and restart
        head_x = food_x; head_y = food_y; hit_body = 1'b1; start_press = 1'b1;
        cyc();
        hit_body = 1'b0; start_press = 1'b0; head_x = 6'd0; head_y = 6'd0;
        chk("die_status", game_status, 2'b11);
        chk("die_score", score, 8'd2);
        chk("die_add_cube", add_cube, 0);
        for (int k = 0; k < 8; k++) begin
            chk("die_stay", game_status, 2'b11);
            chk("die_flash", die_flash, ((k / 2) % 2 == 0));
            chk("die_move_tick", move_tick, 0);
            cyc();
        end
        chk("restart_status", game_status, 2'b00);
        chk("restart_rst_n", snake_rst_n, 0);
        chk("restart_flash", die_flash, 1);
        chk("restart_food", food_valid, 0);
        cyc();
        chk("back_start", game_status, 2'b01);
        chk("back_rst_n", snake_rst_n, 1);
        chk("kept_score", score, 8'd2);

        // 6: reset in the middle of DIE
        press();
        chk("new_game_score", score, 0);
        wait_food();
        eat(7'd3, 8'd1, 1'b1);
        hit_wall = 1'b1;
        cyc();
        hit_wall = 1'b0;
        repeat (2) cyc();
        chk("mid_die_flash", die_flash, 0);
        reset = 1'b1;
        cyc();
        chk("r6_status", game_status, 2'b01);
        chk("r6_die_flash", die_flash, 1);
        chk("r6_rst_n", snake_rst_n, 0);
        chk("r6_score", score, 0);
        chk("r6_food", {food_valid, food_x, food_y}, 0);
        chk("r6_add_move", {add_cube, move_tick}, 0);
        chk("r6_lfsr", dut.u_food.r_lfsr, 12'hACE);
        reset = 1'b0;
        repeat (2) cyc();
        press();
        wait_food();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
